// File: rtl/axi_sram_slave.sv
// AXI responder backed by a byte-laned, word-addressed synchronous RAM; one transaction at a time.
// Optional per-beat wait states are compiled in with `define AXI_SLV_WAIT_EN.
module axi_sram_slave #(
    parameter int AW_WORDS    = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int DEPTH = 1 << AW_WORDS;

`ifdef AXI_SLV_WAIT_EN
    typedef enum logic [2:0] {IDLE, RFETCH, RDATA, WDATA, BRESP, WAIT} state_t;
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES);
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           wr_q, wr_d;
`else
    typedef enum logic [2:0] {IDLE, RFETCH, RDATA, WDATA, BRESP} state_t;
`endif

    state_t              state_q, state_d;
    logic [3:0]          id_q, id_d;
    logic [AW_WORDS-1:0] idx_q, idx_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          beat_q, beat_d;
    logic                fixed_q, fixed_d;
    logic                ram_re, ram_we;
    logic                last_beat;
    logic [AW_WORDS-1:0] idx_next;
    logic [31:0]         ram_rd;

    assign last_beat = (beat_q == len_q);
    assign idx_next  = fixed_q ? idx_q : idx_q + AW_WORDS'(1);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        fixed_d = fixed_q;
        ram_re  = 1'b0;
        ram_we  = 1'b0;
`ifdef AXI_SLV_WAIT_EN
        wait_cnt_d = wait_cnt_q;
        wr_d       = wr_q;
`endif
        case (state_q)
            IDLE: begin
                // Write address wins a tie so a store followed by a load stays ordered.
                if (awvalid) begin
                    id_d    = awid;
                    idx_d   = awaddr[AW_WORDS+1:2];
                    len_d   = {4'b0000, awlen};
                    fixed_d = (awburst == 2'b00);
                    beat_d  = 8'd0;
                    state_d = WDATA;
`ifdef AXI_SLV_WAIT_EN
                    wr_d    = 1'b1;
`endif
                end else if (arvalid) begin
                    id_d    = arid;
                    idx_d   = araddr[AW_WORDS+1:2];
                    len_d   = arlen;
                    fixed_d = (arburst == 2'b00);
                    beat_d  = 8'd0;
                    state_d = RFETCH;
`ifdef AXI_SLV_WAIT_EN
                    wr_d    = 1'b0;
`endif
                end
            end
            RFETCH: begin
                ram_re = 1'b1;
`ifdef AXI_SLV_WAIT_EN
                if (WAIT_CYCLES > 0) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = RDATA;
                end
`else
                state_d = RDATA;
`endif
            end
            RDATA: begin
                if (rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_next;
                        beat_d  = beat_q + 8'd1;
                        state_d = RFETCH;
                    end
                end
            end
            WDATA: begin
                if (wvalid) begin
                    ram_we = 1'b1;
                    // Burst length is counted here; wlast from the master is not trusted.
                    if (last_beat) begin
`ifdef AXI_SLV_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            state_d    = WAIT;
                            wait_cnt_d = WAIT_LOAD;
                        end else begin
                            state_d = BRESP;
                        end
`else
                        state_d = BRESP;
`endif
                    end else begin
                        idx_d  = idx_next;
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            BRESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end
`ifdef AXI_SLV_WAIT_EN
            WAIT: begin
                if (wait_cnt_q <= WCW'(1)) begin
                    state_d = wr_q ? BRESP : RDATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            id_q    <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            fixed_q <= 1'b0;
`ifdef AXI_SLV_WAIT_EN
            wait_cnt_q <= '0;
            wr_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            fixed_q <= fixed_d;
`ifdef AXI_SLV_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
`endif
        end
    end

    // One RAM per byte lane so strobed writes map onto plain block RAM; contents are never reset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge aclk) begin
            if (ram_we && wstrb[gi]) begin
                mem_lane[idx_q] <= wdata[gi*8 +: 8];
            end
            if (ram_re) begin
                rd_q <= mem_lane[idx_q];
            end
        end

        assign ram_rd[gi*8 +: 8] = rd_q;
    end

    assign awready = (state_q == IDLE);
    assign arready = (state_q == IDLE) && !awvalid;
    assign wready  = (state_q == WDATA);
    assign rvalid  = (state_q == RDATA);
    assign bvalid  = (state_q == BRESP);
    assign rlast   = rvalid && last_beat;
    // The read register only changes in RFETCH, so data holds steady under backpressure.
    assign rdata   = rvalid ? ram_rd : 32'd0;
    assign rid     = id_q;
    assign bid     = id_q;
    assign rresp   = 2'b00;
    assign bresp   = 2'b00;

    logic unused_ok;
    assign unused_ok = &{1'b0, arsize, awsize, wid, wlast,
                         araddr[31:AW_WORDS+2], araddr[1:0],
                         awaddr[31:AW_WORDS+2], awaddr[1:0]
`ifndef AXI_SLV_WAIT_EN
                         , 1'(WAIT_CYCLES)
`endif
                        };
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI responder (slave) end of the CPU's memory bus. It answers the ar/r/aw/w/b requests that the core's AXI master issues.
- Backed by an internal word-addressed RAM. Used as the simulation and bring-up memory behind the CPU top.
- One transaction in flight at a time. Supports INCR and FIXED bursts, byte-strobed writes and fixed OKAY responses.

Parameters:
- AW_WORDS, 12: word-address width. RAM depth is 2^AW_WORDS 32-bit words.
- WAIT_CYCLES, 2: wait states per beat. Used only when AXI_SLV_WAIT_EN is defined.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- arid  in  4  read id.
- araddr  in  32  read byte address.
- arlen  in  8  read beats minus 1.
- arsize  in  3  ignored; reads always return the full word.
- arburst  in  2  00 = FIXED, any other value = INCR.
- arvalid  in  1 / arready  out  1: read address handshake.
- rid  out  4 / rdata  out  32 / rresp  out  2 / rlast  out  1: read data channel.
- rvalid  out  1 / rready  in  1: read data handshake.
- awid  in  4 / awaddr  in  32 / awlen  in  4 / awsize  in  3 / awburst  in  2: write address channel; awsize ignored.
- awvalid  in  1 / awready  out  1: write address handshake.
- wid  in  4 / wdata  in  32 / wstrb  in  4 / wlast  in  1: write data channel; wid and wlast ignored.
- wvalid  in  1 / wready  out  1: write data handshake.
- bid  out  4 / bresp  out  2: write response channel.
- bvalid  out  1 / bready  in  1: write response handshake.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low (aresetn), on the single clock aclk.
  - While aresetn = 0: state = IDLE; rvalid, bvalid, rlast = 0; rdata, rid, bid = 0.
  - RAM contents are not reset.
  - Reset mid-burst abandons the transaction with no response.
- Ready signals are combinational from state:
  - awready = (state == IDLE).
  - arready = (state == IDLE) & ~awvalid. Writes win ties so a store-then-load stays ordered.
  - wready = (state == WDATA).
- rresp and bresp are tied to 2'b00.
- Word index = addr[AW_WORDS+1:2]. Upper address bits alias. Index increments modulo 2^AW_WORDS for INCR and holds for FIXED.
- FSM states:
  - IDLE:
    - On an aw handshake: latch awid, index, awlen, burst; beat counter = 0; go to WDATA.
    - Otherwise, on an ar handshake: latch arid, index, arlen, burst; beat = 0; go to RFETCH.
  - RFETCH: synchronous RAM read of the index; go to RDATA.
  - RDATA:
    - rvalid = 1; rdata and rid are registered; rlast = (beat == len).
    - rdata, rid and rlast hold stable while rready = 0.
    - On rready: if last beat, go to IDLE; else advance index, beat+1, go to RFETCH.
    - Latency: AR handshake in cycle N gives first rvalid in cycle N+2. Each beat takes at least 2 cycles.
  - WDATA:
    - On wvalid: write byte lanes where wstrb[i] = 1 (byte i = wdata[8i+7:8i]).
    - If beat == len, go to BRESP; else advance index, beat+1.
    - The burst ends by count; wlast is ignored.
  - BRESP: bvalid = 1, bid = latched awid; on bready go to IDLE.
- Back-to-back transactions: a new aw/ar is accepted no earlier than the cycle after returning to IDLE.
- A write whose data targets an index then read back returns the new data (no read-before-write hazard, since there is one transaction at a time).
- Beat counter is 8 bits, so arlen = 255 gives 256 beats. awlen is zero-extended.

Optional Feature:
- Macro: AXI_SLV_WAIT_EN.
- Defined: a WAIT state with a down-counter loaded with WAIT_CYCLES.
  - It sits between RFETCH and RDATA on every read beat, and before BRESP.
  - First rvalid moves to N+2+WAIT_CYCLES.
  - WAIT_CYCLES = 0 behaves as undefined.
- Undefined: no WAIT state and no counter logic; timing is as in Behaviour.

Test Plan:
- Single write then read:
  - Stimulus: aw addr 0x00000010, awlen 0, wdata 0xDEADBEEF, wstrb 1111, then ar addr 0x10, arlen 0, id 4'h3.
  - Required: bvalid with bresp 00; rdata 0xDEADBEEF, rid 3, rlast 1, rvalid at AR cycle +2.
- INCR read burst:
  - Preload words 0x100..0x10C = 1, 2, 3, 4; ar 0x100, arlen 3.
  - Required: rdata 1, 2, 3, 4; rlast only on the 4th beat.
- Byte strobe:
  - Stimulus: word 0x20 = 0x11223344; write wdata 0xAABBCCDD, wstrb 0101; read back.
  - Required: 0x11BB33DD.
- Simultaneous arvalid and awvalid in IDLE:
  - Required: aw accepted first and arready = 0 that cycle; the read is accepted after BRESP completes and returns the written data.
- Backpressure and aliasing:
  - rready held 0 for 5 cycles: rvalid, rdata and rlast stay stable.
  - With AW_WORDS = 12, read 0x00004000 returns the word at 0x0.
  - FIXED burst arlen 2 returns the same word 3 times.
- Reset mid-burst:
  - Stimulus: aresetn low during beat 2 of a 4-beat read.
  - Required: rvalid = 0 immediately; returns to IDLE; the next read succeeds.
  - With AXI_SLV_WAIT_EN defined and WAIT_CYCLES = 2: first rvalid at N+4.
